// File: rtl/halton_pkg.sv
// halton_pkg: shared constants, helper functions and digit type for the Halton generator
package halton_pkg;

    localparam int MAX_BASE  = 16;
    localparam int MAX_DIG_W = $clog2(MAX_BASE);

    typedef logic [MAX_DIG_W-1:0] digit_t;

    function automatic int pow_int(input int base, input int exp);
        int r;
        r = 1;
        for (int k = 0; k < exp; k++) r = r * base;
        return r;
    endfunction

    function automatic int scramble_off(input int i, input int base);
        return (i + 1) % base;
    endfunction

endpackage

// File: rtl/mod_cnt_base.sv
// mod_cnt_base: one modulo-BASE digit counter with carry in/out for ripple chaining
module mod_cnt_base
    import halton_pkg::*;
#(
    parameter int BASE  = 5,
    parameter int DIG_W = $clog2(BASE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             cin,
    output logic [DIG_W-1:0] out,
    output logic             cout
);

    localparam logic [DIG_W-1:0] TOP = DIG_W'(BASE - 1);

    logic [DIG_W-1:0] cnt_q, cnt_d;

    // restart wins over counting; a digit at BASE-1 wraps to 0 when it advances
    always_comb cnt_d = clr ? '0 : !cin ? cnt_q : (cnt_q == TOP) ? '0 : cnt_q + 1'b1;

    // digit register with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign out  = cnt_q;
    assign cout = cin & (cnt_q == TOP);

endmodule

// File: rtl/halton_seq_gen.sv
// halton_seq_gen: radical-inverse (Halton) sequence generator built from chained mod-BASE digit counters.
// Define HALTON_SCRAMBLE_EN to add a per-digit additive scramble to the output value.
module halton_seq_gen
    import halton_pkg::*;
#(
    parameter int BASE   = 5,
    parameter int DIGITS = 4,
    parameter int DIG_W  = $clog2(BASE),
    parameter int OUT_W  = $clog2(pow_int(BASE, DIGITS))
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clr,
    output logic [OUT_W-1:0]        out,
    output logic [DIGITS*DIG_W-1:0] digits,
    output logic                    cout
);

    if (BASE < 2 || BASE > MAX_BASE || DIGITS < 1) begin : g_bad_param
        $fatal(1, "halton_seq_gen: BASE must be 2..16 and DIGITS must be >= 1");
    end

    logic [DIGITS:0]  carry;
    logic [DIG_W-1:0] d  [DIGITS];
    logic [DIG_W-1:0] sd [DIGITS];
    logic [OUT_W-1:0] sum;

    assign carry[0] = en;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        mod_cnt_base #(
            .BASE (BASE),
            .DIG_W(DIG_W)
        ) u_cnt (
            .clk  (clk),
            .rst_n(rst_n),
            .clr  (clr),
            .cin  (carry[g]),
            .out  (d[g]),
            .cout (carry[g+1])
        );
        assign digits[g*DIG_W +: DIG_W] = d[g];
`ifdef HALTON_SCRAMBLE_EN
        localparam logic [DIG_W:0] OFF = (DIG_W+1)'(scramble_off(g, BASE));
        localparam logic [DIG_W:0] MOD = (DIG_W+1)'(BASE);
        logic [DIG_W:0] s;
        assign s     = {1'b0, d[g]} + OFF;
        assign sd[g] = (s >= MOD) ? DIG_W'(s - MOD) : s[DIG_W-1:0];
`else
        assign sd[g] = d[g];
`endif
    end

    // digit i is weighted by the constant BASE**(DIGITS-1-i), reversing the index digits
    always_comb begin
        sum = '0;
        for (int i = 0; i < DIGITS; i++) sum = sum + OUT_W'(sd[i]) * OUT_W'(pow_int(BASE, DIGITS - 1 - i));
    end

    assign out  = sum;
    assign cout = carry[DIGITS] & rst_n & ~clr;

endmodule

// File: tb/tb_halton_seq_gen.sv
module tb_halton_seq_gen;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, clr = 1'b0;
    logic [4:0] out5;
    logic [5:0] dig5;
    logic       cout5;
    logic [2:0] out2, dig2;
    logic       cout2;

    int total = 0, bad = 0;
    int i5 = 0, i2 = 0;
    int cout_seen = 0, en_cnt = 0;

    typedef struct {
        bit e;
        bit c;
        int o2;
        bit c2;
    } vec_t;
    vec_t tv[11];

`ifdef HALTON_SCRAMBLE_EN
    localparam int OUT5_AT24 = 1;
    localparam int OUT5_AT0  = 7;
`else
    localparam int OUT5_AT24 = 24;
    localparam int OUT5_AT0  = 0;
`endif

    always #5 clk = ~clk;

    halton_seq_gen #(.BASE(5), .DIGITS(2)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .out(out5), .digits(dig5), .cout(cout5)
    );

    halton_seq_gen #(.BASE(2), .DIGITS(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
        .out(out2), .digits(dig2), .cout(cout2)
    );

    // radical inverse of idx: least significant index digit gets the largest weight
    function automatic int ref_out(input int base, input int nd, input int idx);
        int r, v, dd;
        r = 0;
        v = idx;
        for (int i = 0; i < nd; i++) begin
            dd = v % base;
            v  = v / base;
`ifdef HALTON_SCRAMBLE_EN
            dd = (dd + (i + 1) % base) % base;
`endif
            r = r * base + dd;
        end
        return r;
    endfunction

    function automatic int ref_dig(input int base, input int nd, input int w, input int idx);
        int r, v;
        r = 0;
        v = idx;
        for (int i = 0; i < nd; i++) begin
            r = r | ((v % base) << (i * w));
            v = v / base;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("out5", int'(out5), ref_out(5, 2, i5));
        chk("digits5", int'(dig5), ref_dig(5, 2, 3, i5));
        chk("cout5", int'(cout5), int'(en && !clr && rst_n && i5 == 24));
        chk("out2", int'(out2), ref_out(2, 3, i2));
        chk("digits2", int'(dig2), ref_dig(2, 3, 1, i2));
        chk("cout2", int'(cout2), int'(en && !clr && rst_n && i2 == 7));
    endtask

    task automatic upd();
        i5 = (!rst_n || clr) ? 0 : en ? (i5 + 1) % 25 : i5;
        i2 = (!rst_n || clr) ? 0 : en ? (i2 + 1) % 8 : i2;
    endtask

    task automatic cycle(input bit e, input bit c);
        en  = e;
        clr = c;
        @(negedge clk);
        check_all();
        if (cout5) cout_seen++;
        @(posedge clk);
        upd();
        #1;
    endtask

    initial begin
        bit e;
        tv[0]  = '{1, 0, 0, 0};
        tv[1]  = '{1, 0, 4, 0};
        tv[2]  = '{1, 0, 2, 0};
        tv[3]  = '{1, 0, 6, 0};
        tv[4]  = '{1, 0, 1, 0};
        tv[5]  = '{1, 0, 5, 0};
        tv[6]  = '{1, 0, 3, 0};
        tv[7]  = '{1, 0, 7, 1};
        tv[8]  = '{1, 0, 0, 0};
        tv[9]  = '{1, 1, 4, 0};
        tv[10] = '{0, 0, 0, 0};

        en = 1'b1;
        @(negedge clk);
        check_all();
        @(posedge clk);
        upd();
        #1;
        rst_n = 1'b1;
        en    = 1'b0;

`ifdef HALTON_SCRAMBLE_EN
        chk("scr_reset_out5", int'(out5), 7);
        cycle(1'b1, 1'b0);
        chk("scr_step_out5", int'(out5), 12);
        chk("scr_step_digits5", int'(dig5), 1);
        cycle(1'b0, 1'b1);
`endif

        repeat (10) cycle(1'b0, 1'b0);

`ifndef HALTON_SCRAMBLE_EN
        for (int k = 0; k < 11; k++) begin
            en  = tv[k].e;
            clr = tv[k].c;
            @(negedge clk);
            check_all();
            chk("tbl_out2", int'(out2), tv[k].o2);
            chk("tbl_cout2", int'(cout2), int'(tv[k].c2));
            @(posedge clk);
            upd();
            #1;
        end
`endif

        cycle(1'b0, 1'b1);
        repeat (24) cycle(1'b1, 1'b0);
        en = 1'b1;
        @(negedge clk);
        check_all();
        chk("wrap_out5", int'(out5), OUT5_AT24);
        chk("wrap_cout5", int'(cout5), 1);
        @(posedge clk);
        upd();
        #1;
        en = 1'b0;
        @(negedge clk);
        chk("after_wrap_out5", int'(out5), OUT5_AT0);
        chk("after_wrap_digits5", int'(dig5), 0);
        @(posedge clk);
        #1;

        cycle(1'b0, 1'b1);
        cout_seen = 0;
        en_cnt    = 0;
        repeat (500) begin
            e = 1'($urandom_range(0, 1));
            if (e) en_cnt++;
            cycle(e, 1'b0);
        end
        chk("cout_count", cout_seen, en_cnt / 25);

        cycle(1'b0, 1'b1);
        repeat (24) cycle(1'b1, 1'b0);
        en  = 1'b1;
        clr = 1'b1;
        @(negedge clk);
        check_all();
        chk("clr_mask_cout5", int'(cout5), 0);
        @(posedge clk);
        upd();
        #1;
        en  = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        chk("clr_out5", int'(out5), OUT5_AT0);
        @(posedge clk);
        #1;

        repeat (7) cycle(1'b1, 1'b0);
        en    = 1'b1;
        rst_n = 1'b0;
        #1;
        i5 = 0;
        i2 = 0;
        chk("async_out5", int'(out5), OUT5_AT0);
        chk("async_digits5", int'(dig5), 0);
        check_all();
        #1;
        rst_n = 1'b1;
        repeat (6) cycle(1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
